// File: rtl/ifetch_responder_pkg.sv
// ---------------------------------------------------------------------------
// ifetch_responder_pkg
// Shared definitions for the instruction-fetch responder slice:
//   ifrState_t  - responder FSM state encoding (3 bits)
//   INST_NOP    - instruction returned in place of memory data on a fault
//   TIMER_W     - width of the wait-state down-counter
// ---------------------------------------------------------------------------
package ifetch_responder_pkg;

    typedef enum logic [2:0] {
        IFR_IDLE  = 3'd0,
        IFR_ISSUE = 3'd1,
        IFR_MEM   = 3'd2,
        IFR_WAIT  = 3'd3,
        IFR_RESP  = 3'd4
    } ifrState_t;

    // addi x0, x0, 0 -- a harmless filler so the fetch stage never sees garbage
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    localparam int TIMER_W = 4;

endpackage

// File: rtl/ifetch_responder_if.sv
// ---------------------------------------------------------------------------
// ifetch_responder_if
// Request/response bus between PrePc (master) and the instruction responder
// (slave).
//   reqValid/reqAddr/flush              : master -> responder
//   reqReady                            : responder -> master, high in IDLE
//   instOut/instAddrOut/readShakeHands  : returned instruction + fill strobe
//   accessFault                         : qualifies the strobe on a bad request
// ---------------------------------------------------------------------------
interface ifetch_responder_if #(
    parameter int ADDR_W = 64,
    parameter int INST_W = 32
);
    logic              reqValid;
    logic [ADDR_W-1:0] reqAddr;
    logic              reqReady;
    logic              flush;
    logic [INST_W-1:0] instOut;
    logic [ADDR_W-1:0] instAddrOut;
    logic              readShakeHands;
    logic              accessFault;

    modport master (
        output reqValid, reqAddr, flush,
        input  reqReady, instOut, instAddrOut, readShakeHands, accessFault
    );

    modport slave (
        input  reqValid, reqAddr, flush,
        output reqReady, instOut, instAddrOut, readShakeHands, accessFault
    );
endinterface

// File: rtl/ifr_wait_timer.sv
// ---------------------------------------------------------------------------
// ifr_wait_timer
// Loadable 4-bit down-counter that times the responder's wait states.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : load i_value this cycle (takes priority over counting)
//   i_value        : number of wait cycles to time
//   o_done         : high while the count is 1, i.e. in the last wait cycle
// ---------------------------------------------------------------------------
module ifr_wait_timer
    import ifetch_responder_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_value,
    output logic               o_done
);

    logic [TIMER_W-1:0] r_count;

    // Count down towards zero after a load; parking at zero keeps a stale
    // count from ever wrapping around and raising o_done spuriously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == TIMER_W'(1));

endmodule

// File: rtl/ifetch_responder.sv
// ---------------------------------------------------------------------------
// ifetch_responder
// Serves PrePc prefetch reads from a synchronous instruction memory: one
// request per handshake, optional wait states, and a one-cycle
// readShakeHands pulse that the I-Cache uses as its fill strobe.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus            : slave side of ifetch_responder_if (request/response)
//   o_memEn        : memory read enable (data returns the following cycle)
//   o_memAddr      : memory word index
//   i_memRdata     : memory read data
// ---------------------------------------------------------------------------
module ifetch_responder
    import ifetch_responder_pkg::*;
#(
    parameter int              ADDR_W    = 64,
    parameter int              INST_W    = 32,
    parameter int              MEM_AW    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(64'h8000_0000),
    parameter int              WAIT_CYC  = 0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    ifetch_responder_if.slave   bus,
    output logic                o_memEn,
    output logic [MEM_AW-1:0]   o_memAddr,
    input  logic [INST_W-1:0]   i_memRdata
);

    localparam logic [ADDR_W-1:0] DEPTH_WORDS = ADDR_W'(1) << MEM_AW;

    ifrState_t         r_state;
    ifrState_t         w_nextState;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_lastAddr;
    logic [INST_W-1:0] r_data;
    logic [INST_W-1:0] r_lastInst;
    logic              r_fault;
    logic [MEM_AW-1:0] r_memIdx;
    logic [ADDR_W-1:0] w_offset;
    logic [ADDR_W-1:0] w_wordIdx;
    logic              w_fault;
    logic              w_accept;
    logic              w_inResp;
    logic              w_pulse;
    logic              w_timerLoad;
    logic              w_timerDone;

    // The range check uses the full-width word index, so an address far above
    // the memory (or one that underflows below BASE_ADDR) can never alias
    // into it after truncation.
    assign w_offset  = bus.reqAddr - BASE_ADDR;
    assign w_wordIdx = w_offset >> 2;
    assign w_fault   = (bus.reqAddr[1:0] != 2'b00) ||
                       (bus.reqAddr < BASE_ADDR) ||
                       (w_wordIdx >= DEPTH_WORDS);
    assign w_accept  = (r_state == IFR_IDLE) && bus.reqValid && !bus.flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IFR_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Flush aborts any request in flight; the WAIT state is bypassed entirely
    // when no wait cycles are configured.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IFR_IDLE:  if (w_accept) w_nextState = IFR_ISSUE;
            IFR_ISSUE: w_nextState = bus.flush ? IFR_IDLE : IFR_MEM;
            IFR_MEM: begin
                if (bus.flush)          w_nextState = IFR_IDLE;
                else if (WAIT_CYC == 0) w_nextState = IFR_RESP;
                else                    w_nextState = IFR_WAIT;
            end
            IFR_WAIT: begin
                if (bus.flush)        w_nextState = IFR_IDLE;
                else if (w_timerDone) w_nextState = IFR_RESP;
            end
            IFR_RESP:  w_nextState = IFR_IDLE;
            default:   w_nextState = IFR_IDLE;
        endcase
    end

    // Request latch, memory capture and the "last delivered" output copies.
    // The last-delivered copies only update on a pulse, so a flushed response
    // leaves the visible outputs as they were.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr     <= BASE_ADDR;
            r_fault    <= 1'b0;
            r_memIdx   <= '0;
            r_data     <= '0;
            r_lastInst <= '0;
            r_lastAddr <= BASE_ADDR;
        end else begin
            if (w_accept) begin
                r_addr   <= bus.reqAddr;
                r_fault  <= w_fault;
                r_memIdx <= w_wordIdx[MEM_AW-1:0];
            end
            if (r_state == IFR_MEM) begin
                r_data <= r_fault ? INST_W'(INST_NOP) : i_memRdata;
            end
            if (w_pulse) begin
                r_lastInst <= r_data;
                r_lastAddr <= r_addr;
            end
        end
    end

    assign w_timerLoad = (r_state == IFR_MEM);

    ifr_wait_timer u_waitTimer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_timerLoad),
        .i_value (TIMER_W'(WAIT_CYC)),
        .o_done  (w_timerDone)
    );

    assign w_inResp           = (r_state == IFR_RESP);
    assign w_pulse            = w_inResp && !bus.flush;
    assign bus.reqReady       = (r_state == IFR_IDLE);
    assign bus.readShakeHands = w_pulse;
    assign bus.accessFault    = w_pulse && r_fault;
    assign bus.instOut        = w_inResp ? r_data : r_lastInst;
    assign bus.instAddrOut    = w_inResp ? r_addr : r_lastAddr;

    assign o_memEn   = (r_state == IFR_ISSUE) && !r_fault && !bus.flush;
    assign o_memAddr = r_memIdx;

endmodule

// File: tb/tb_ifetch_responder.sv
// ---------------------------------------------------------------------------
// tb_ifetch_responder
// Directed bench for ifetch_responder. Two instances run side by side, one
// with no wait states and one with three, each backed by its own read port
// onto a shared instruction memory image (mem[i] = 0xC0DE0000 | i, except
// mem[4] = 0x00A00093). Inputs change 1 time unit after the rising edge and
// outputs are sampled in the same window.
// ---------------------------------------------------------------------------
module tb_ifetch_responder;

    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memEn0, memEn3;
    logic [9:0]  memAddr0, memAddr3;
    logic [31:0] memRdata0, memRdata3;
    logic [31:0] mem [1024];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] expInst;
        logic [9:0]  expIdx;
        logic        expFault;
        string       name;
    } vec_t;

    vec_t vecs [8];

    ifetch_responder_if #(.ADDR_W(64), .INST_W(32)) bus0 ();
    ifetch_responder_if #(.ADDR_W(64), .INST_W(32)) bus3 ();

    ifetch_responder #(.MEM_AW(10), .WAIT_CYC(0)) dut0 (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .bus        (bus0),
        .o_memEn    (memEn0),
        .o_memAddr  (memAddr0),
        .i_memRdata (memRdata0)
    );

    ifetch_responder #(.MEM_AW(10), .WAIT_CYC(3)) dut3 (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .bus        (bus3),
        .o_memEn    (memEn3),
        .o_memAddr  (memAddr3),
        .i_memRdata (memRdata3)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Synchronous instruction memory: data appears the cycle after enable.
    always @(posedge clk) begin
        if (memEn0) memRdata0 <= mem[memAddr0];
        if (memEn3) memRdata3 <= mem[memAddr3];
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pulseOf(input int sel);
        return (sel == 0) ? bus0.readShakeHands : bus3.readShakeHands;
    endfunction

    function automatic logic readyOf(input int sel);
        return (sel == 0) ? bus0.reqReady : bus3.reqReady;
    endfunction

    function automatic logic [31:0] instOf(input int sel);
        return (sel == 0) ? bus0.instOut : bus3.instOut;
    endfunction

    function automatic logic [63:0] addrOf(input int sel);
        return (sel == 0) ? bus0.instAddrOut : bus3.instAddrOut;
    endfunction

    task automatic driveReq(input int sel, input logic valid, input logic [63:0] addr);
        if (sel == 0) begin
            bus0.reqValid = valid;
            bus0.reqAddr  = addr;
        end else begin
            bus3.reqValid = valid;
            bus3.reqAddr  = addr;
        end
    endtask

    // One request into both instances, then nine cycles of per-cycle checks:
    // pulse at T+3 / T+6, ready low until after the pulse, memEn only in T+1.
    task automatic applyStimulus(input vec_t v);
        driveReq(0, 1'b1, v.addr);
        driveReq(3, 1'b1, v.addr);
        #1;
        checkOutput({v.name, " ready0 T"}, bus0.reqReady, 1);
        checkOutput({v.name, " ready3 T"}, bus3.reqReady, 1);
        for (int cyc = 1; cyc <= 9; cyc++) begin
            nextCycle();
            if (cyc == 1) begin
                bus0.reqValid = 1'b0;
                bus3.reqValid = 1'b0;
            end
            #1;
            checkOutput($sformatf("%s pulse0 c%0d", v.name, cyc), bus0.readShakeHands, cyc == 3);
            checkOutput($sformatf("%s pulse3 c%0d", v.name, cyc), bus3.readShakeHands, cyc == 6);
            checkOutput($sformatf("%s ready0 c%0d", v.name, cyc), bus0.reqReady, cyc >= 4);
            checkOutput($sformatf("%s ready3 c%0d", v.name, cyc), bus3.reqReady, cyc >= 7);
            checkOutput($sformatf("%s memEn0 c%0d", v.name, cyc), memEn0, (cyc == 1) && !v.expFault);
            checkOutput($sformatf("%s memEn3 c%0d", v.name, cyc), memEn3, (cyc == 1) && !v.expFault);
            checkOutput($sformatf("%s fault0 c%0d", v.name, cyc), bus0.accessFault, (cyc == 3) && v.expFault);
            checkOutput($sformatf("%s fault3 c%0d", v.name, cyc), bus3.accessFault, (cyc == 6) && v.expFault);
            if (cyc == 1 && !v.expFault) begin
                checkOutput({v.name, " memAddr0"}, memAddr0, v.expIdx);
                checkOutput({v.name, " memAddr3"}, memAddr3, v.expIdx);
            end
            if (cyc == 3) begin
                checkOutput({v.name, " inst0"}, bus0.instOut, v.expInst);
                checkOutput({v.name, " iaddr0"}, bus0.instAddrOut, v.addr);
            end
            if (cyc == 6) begin
                checkOutput({v.name, " inst3"}, bus3.instOut, v.expInst);
                checkOutput({v.name, " iaddr3"}, bus3.instAddrOut, v.addr);
            end
        end
    endtask

    // ReqValid held high across three sequential addresses on one instance.
    task automatic backToBack(input int sel, input int firstLat, input int period, input int budget);
        logic [63:0] addrs [3];
        logic [31:0] insts [3];
        int issued = 0;
        int pulses = 0;
        addrs[0] = 64'h8000_0000; insts[0] = 32'hC0DE_0000;
        addrs[1] = 64'h8000_0004; insts[1] = 32'hC0DE_0001;
        addrs[2] = 64'h8000_0008; insts[2] = 32'hC0DE_0002;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (issued < 3) driveReq(sel, 1'b1, addrs[issued]);
            else            driveReq(sel, 1'b0, 64'h0);
            #1;
            if (pulseOf(sel)) begin
                if (pulses < 3) begin
                    checkOutput($sformatf("b2b%0d cycle p%0d", sel, pulses), 64'(cyc), 64'(firstLat + period * pulses));
                    checkOutput($sformatf("b2b%0d inst p%0d", sel, pulses), instOf(sel), insts[pulses]);
                    checkOutput($sformatf("b2b%0d addr p%0d", sel, pulses), addrOf(sel), addrs[pulses]);
                end else begin
                    checkOutput($sformatf("b2b%0d extra pulse c%0d", sel, cyc), 1, 0);
                end
                pulses++;
            end
            if (issued < 3 && readyOf(sel)) issued++;
            nextCycle();
        end
        driveReq(sel, 1'b0, 64'h0);
        checkOutput($sformatf("b2b%0d pulse count", sel), 64'(pulses), 3);
    endtask

    // Flush raised together with ReqValid in IDLE: nothing may start.
    task automatic flushIdle();
        driveReq(0, 1'b1, 64'h8000_0010);
        driveReq(3, 1'b1, 64'h8000_0010);
        bus0.flush = 1'b1;
        bus3.flush = 1'b1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            nextCycle();
            if (cyc == 1) begin
                driveReq(0, 1'b0, 64'h0);
                driveReq(3, 1'b0, 64'h0);
                bus0.flush = 1'b0;
                bus3.flush = 1'b0;
            end
            #1;
            checkOutput($sformatf("flushIdle ready0 c%0d", cyc), bus0.reqReady, 1);
            checkOutput($sformatf("flushIdle ready3 c%0d", cyc), bus3.reqReady, 1);
            checkOutput($sformatf("flushIdle memEn0 c%0d", cyc), memEn0, 0);
            checkOutput($sformatf("flushIdle pulse0 c%0d", cyc), bus0.readShakeHands, 0);
            checkOutput($sformatf("flushIdle pulse3 c%0d", cyc), bus3.readShakeHands, 0);
        end
    endtask

    // Flush during ISSUE on both instances: memEn is forced low, back to IDLE.
    task automatic flushIssue();
        driveReq(0, 1'b1, 64'h8000_0010);
        driveReq(3, 1'b1, 64'h8000_0010);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            nextCycle();
            if (cyc == 1) begin
                driveReq(0, 1'b0, 64'h0);
                driveReq(3, 1'b0, 64'h0);
            end
            bus0.flush = (cyc == 1);
            bus3.flush = (cyc == 1);
            #1;
            checkOutput($sformatf("flushIssue memEn0 c%0d", cyc), memEn0, 0);
            checkOutput($sformatf("flushIssue memEn3 c%0d", cyc), memEn3, 0);
            checkOutput($sformatf("flushIssue ready0 c%0d", cyc), bus0.reqReady, cyc >= 2);
            checkOutput($sformatf("flushIssue ready3 c%0d", cyc), bus3.reqReady, cyc >= 2);
            checkOutput($sformatf("flushIssue pulse0 c%0d", cyc), bus0.readShakeHands, 0);
            checkOutput($sformatf("flushIssue pulse3 c%0d", cyc), bus3.readShakeHands, 0);
        end
        bus0.flush = 1'b0;
        bus3.flush = 1'b0;
    endtask

    // Flush coincident with RESP (T+3 on dut0, T+6 on dut3): the pulse and
    // the fault flag of a faulting request are both suppressed.
    task automatic flushResp();
        driveReq(0, 1'b1, 64'h8000_0002);
        driveReq(3, 1'b1, 64'h8000_0002);
        for (int cyc = 1; cyc <= 9; cyc++) begin
            nextCycle();
            if (cyc == 1) begin
                driveReq(0, 1'b0, 64'h0);
                driveReq(3, 1'b0, 64'h0);
            end
            bus0.flush = (cyc == 3);
            bus3.flush = (cyc == 6);
            #1;
            checkOutput($sformatf("flushResp pulse0 c%0d", cyc), bus0.readShakeHands, 0);
            checkOutput($sformatf("flushResp pulse3 c%0d", cyc), bus3.readShakeHands, 0);
            checkOutput($sformatf("flushResp fault0 c%0d", cyc), bus0.accessFault, 0);
            checkOutput($sformatf("flushResp fault3 c%0d", cyc), bus3.accessFault, 0);
            checkOutput($sformatf("flushResp ready0 c%0d", cyc), bus0.reqReady, cyc >= 4);
            checkOutput($sformatf("flushResp ready3 c%0d", cyc), bus3.reqReady, cyc >= 7);
        end
        bus0.flush = 1'b0;
        bus3.flush = 1'b0;
    endtask

    // Reset asserted while dut3 sits in WAIT: the request is dropped.
    task automatic resetMidWait();
        driveReq(3, 1'b1, 64'h8000_0010);
        nextCycle();
        driveReq(3, 1'b0, 64'h0);
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("rstWait busy before reset", bus3.reqReady, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("rstWait ready3", bus3.reqReady, 1);
        checkOutput("rstWait pulse3", bus3.readShakeHands, 0);
        checkOutput("rstWait iaddr3", bus3.instAddrOut, BASE);
        checkOutput("rstWait inst3", bus3.instOut, 0);
        checkOutput("rstWait iaddr0", bus0.instAddrOut, BASE);
        nextCycle();
        rst_n = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            nextCycle();
            checkOutput($sformatf("rstWait no pulse c%0d", cyc), bus3.readShakeHands, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        driveReq(0, 1'b0, 64'h0);
        driveReq(3, 1'b0, 64'h0);
        bus0.flush = 1'b0;
        bus3.flush = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[4] = 32'h00A0_0093;

        vecs[0] = '{64'h8000_0010,          32'h00A0_0093, 10'h004, 1'b0, "basic"};
        vecs[1] = '{64'h8000_0000,          32'hC0DE_0000, 10'h000, 1'b0, "first word"};
        vecs[2] = '{64'h8000_0FFC,          32'hC0DE_03FF, 10'h3FF, 1'b0, "last word"};
        vecs[3] = '{64'h8000_0404,          32'hC0DE_0101, 10'h101, 1'b0, "mid word"};
        vecs[4] = '{64'h8000_0002,          NOP,           10'h000, 1'b1, "misaligned"};
        vecs[5] = '{64'h7FFF_FFFC,          NOP,           10'h000, 1'b1, "below base"};
        vecs[6] = '{64'h8000_1000,          NOP,           10'h000, 1'b1, "above top"};
        vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFC, NOP,          10'h000, 1'b1, "wrap"};

        repeat (3) nextCycle();
        checkOutput("reset ready0", bus0.reqReady, 1);
        checkOutput("reset ready3", bus3.reqReady, 1);
        checkOutput("reset pulse0", bus0.readShakeHands, 0);
        checkOutput("reset fault0", bus0.accessFault, 0);
        checkOutput("reset inst0", bus0.instOut, 0);
        checkOutput("reset iaddr0", bus0.instAddrOut, BASE);
        checkOutput("reset memEn0", memEn0, 0);
        checkOutput("reset memAddr0", memAddr0, 0);
        checkOutput("reset iaddr3", bus3.instAddrOut, BASE);
        rst_n = 1'b1;
        nextCycle();

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        flushIdle();
        flushIssue();
        applyStimulus('{64'h8000_0008, 32'hC0DE_0002, 10'h002, 1'b0, "after flushIssue"});
        flushResp();
        applyStimulus('{64'h8000_0404, 32'hC0DE_0101, 10'h101, 1'b0, "after flushResp"});

        backToBack(0, 3, 4, 16);
        backToBack(3, 6, 7, 26);

        resetMidWait();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
